// File: rtl/stim_pkg.sv
// Shared constants, state encoding and LCG step for the fuzz-harness stimulus sequencer.
package stim_pkg;

    localparam logic [31:0] LCG_MUL = 32'h41C64E6D;
    localparam logic [31:0] LCG_INC = 32'h3039;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RESET  = 3'd1,
        SETTLE = 3'd2,
        RUN    = 3'd3,
        DONE   = 3'd4
    } stim_state_t;

    function automatic logic [31:0] lcg_next(input logic [31:0] x);
        return x * LCG_MUL + LCG_INC;
    endfunction

endpackage

// File: rtl/stim_sequencer_if.sv
// Bundles the bench-facing control/status and the DUT-facing stimulus/response of the sequencer.
interface stim_sequencer_if #(
    parameter int IN_W  = 136,
    parameter int OUT_W = 159
);
    // Handshake: start is a single-cycle request, accepted only on a clock where busy
    // is low (IDLE or DONE); seed/num_cycles are sampled on that same edge. A start seen
    // while busy is high is dropped, and done stays high until the next accepted start.
    logic             start;
    logic [31:0]      seed;
    logic [31:0]      num_cycles;
    logic             busy;
    logic             done;
    logic [31:0]      cyc_cnt;
    logic [31:0]      signature;
    logic             dut_rst_n;
    logic [IN_W-1:0]  in_flat;
    logic [OUT_W-1:0] out_flat;

    modport master (
        output start, seed, num_cycles, out_flat,
        input  busy, done, cyc_cnt, signature, dut_rst_n, in_flat
    );

    modport slave (
        input  start, seed, num_cycles, out_flat,
        output busy, done, cyc_cnt, signature, dut_rst_n, in_flat
    );

endinterface

// File: rtl/lcg_vector_gen.sv
// Combinational expansion of one LCG state into a chained-word stimulus vector.
module lcg_vector_gen
    import stim_pkg::*;
#(
    parameter int IN_W = 136
) (
    input  logic [31:0]     s_in,
    output logic [IN_W-1:0] vec,
    output logic [31:0]     s_out
);

    localparam int WORDS = (IN_W + 31) / 32;

    logic [31:0] words [WORDS];

    always_comb begin : p_chain
        logic [31:0] w;
        w = s_in;
        for (int k = 0; k < WORDS; k++) begin
            w        = lcg_next(w);
            words[k] = w;
        end
        s_out = w;
    end

    // The top word is truncated to whatever bits remain above the last full word.
    for (genvar k = 0; k < WORDS; k++) begin : g_word
        if ((k + 1) * 32 <= IN_W) begin : g_full
            assign vec[32*k +: 32] = words[k];
        end else begin : g_part
            assign vec[IN_W-1:32*k] = words[k][IN_W-32*k-1:0];
        end
    end

endmodule

// File: rtl/stim_sequencer.sv
// Reset/stimulus controller for the fuzz DUT: reset pulse, LCG vectors per clock,
// applied-cycle count and a MISR signature of the DUT response.
module stim_sequencer
    import stim_pkg::*;
#(
    parameter int IN_W       = 136,
    parameter int OUT_W      = 159,
    parameter int RST_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    stim_sequencer_if.slave bus,
    output stim_state_t dbg_state_o
);

    localparam int OWORDS = (OUT_W + 31) / 32;
    localparam int RCW    = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    stim_state_t      state_q, state_d;
    logic [RCW-1:0]   rst_cnt_q, rst_cnt_d;
    logic [31:0]      num_q, num_d;
    logic [31:0]      lcg_q, lcg_d;
    logic [IN_W-1:0]  in_flat_q, in_flat_d;
    logic [31:0]      cyc_q, cyc_d;
    logic [31:0]      sig_q, sig_d;

    logic [31:0]      gen_s_in;
    logic [31:0]      gen_s_out;
    logic [IN_W-1:0]  gen_vec;
    logic [31:0]      out_slice [OWORDS];
    logic [31:0]      fold;

    // One generator serves both the seed expansion on start and the per-clock RUN step.
    assign gen_s_in = (state_q == RUN) ? lcg_q : bus.seed;

    lcg_vector_gen #(.IN_W(IN_W)) u_gen (
        .s_in  (gen_s_in),
        .vec   (gen_vec),
        .s_out (gen_s_out)
    );

    for (genvar k = 0; k < OWORDS; k++) begin : g_slice
        if ((k + 1) * 32 <= OUT_W) begin : g_full
            assign out_slice[k] = bus.out_flat[32*k +: 32];
        end else begin : g_pad
            assign out_slice[k] = {{(32*OWORDS-OUT_W){1'b0}}, bus.out_flat[OUT_W-1:32*k]};
        end
    end

    always_comb begin
        fold = '0;
        for (int k = 0; k < OWORDS; k++) begin
            fold = fold ^ out_slice[k];
        end
    end

    always_comb begin
        state_d   = state_q;
        rst_cnt_d = rst_cnt_q;
        num_d     = num_q;
        lcg_d     = lcg_q;
        in_flat_d = in_flat_q;
        cyc_d     = cyc_q;
        sig_d     = sig_q;
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d   = RESET;
                    rst_cnt_d = '0;
                    num_d     = bus.num_cycles;
                    in_flat_d = gen_vec;
                    lcg_d     = gen_s_out;
                    cyc_d     = '0;
                    sig_d     = '0;
                end
            end
            RESET: begin
                if (rst_cnt_q == RCW'(RST_CYCLES - 1)) begin
                    state_d = SETTLE;
                end else begin
                    rst_cnt_d = rst_cnt_q + RCW'(1);
                end
            end
            SETTLE: begin
                state_d = (num_q == 32'd0) ? DONE : RUN;
            end
            RUN: begin
                sig_d     = {sig_q[30:0], sig_q[31]} ^ fold;
                in_flat_d = gen_vec;
                lcg_d     = gen_s_out;
                cyc_d     = cyc_q + 32'd1;
                // Compare before wrap so a full 2^32-1 run ends exactly at its count.
                if (cyc_q + 32'd1 == num_q) begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rst_cnt_q <= '0;
            num_q     <= '0;
            lcg_q     <= '0;
            in_flat_q <= '0;
            cyc_q     <= '0;
            sig_q     <= '0;
        end else begin
            state_q   <= state_d;
            rst_cnt_q <= rst_cnt_d;
            num_q     <= num_d;
            lcg_q     <= lcg_d;
            in_flat_q <= in_flat_d;
            cyc_q     <= cyc_d;
            sig_q     <= sig_d;
        end
    end

    assign bus.busy      = (state_q == RESET) || (state_q == SETTLE) || (state_q == RUN);
    assign bus.done      = (state_q == DONE);
    assign bus.dut_rst_n = (state_q == SETTLE) || (state_q == RUN) || (state_q == DONE);
    assign bus.in_flat   = in_flat_q;
    assign bus.cyc_cnt   = cyc_q;
    assign bus.signature = sig_q;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_stim_sequencer.sv
// Randomised scoreboard bench for stim_sequencer against a cycle-indexed behavioural model.
module tb_stim_sequencer;
    import stim_pkg::*;

    localparam int IN_W  = 136;
    localparam int OUT_W = 159;
    localparam int R     = 2;
    localparam logic [31:0] MUL = 32'h41C64E6D;
    localparam logic [31:0] INC = 32'h3039;

    typedef struct packed {
        logic            busy;
        logic            done;
        logic            drst;
        logic [IN_W-1:0] in_flat;
        logic [31:0]     cyc;
        logic [31:0]     sig;
    } exp_t;
    localparam int EXP_W = $bits(exp_t);

    logic              clk = 1'b0;
    logic              rst_n;
    stim_state_t       dbg_state;
    logic [EXP_W-1:0]  exp_q[$];
    exp_t              mon_e;
    int                checks = 0;
    int                errors = 0;

    stim_sequencer_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

    stim_sequencer #(.IN_W(IN_W), .OUT_W(OUT_W), .RST_CYCLES(R)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus.slave),
        .dbg_state_o (dbg_state)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // reference model
    function automatic logic [31:0] m_step(input logic [31:0] x);
        return x * MUL + INC;
    endfunction

    function automatic logic [IN_W-1:0] m_vector(input logic [31:0] s, output logic [31:0] s_end);
        logic [191:0] acc;
        logic [31:0]  x;
        acc = '0;
        x   = s;
        for (int k = 0; k < (IN_W + 31) / 32; k++) begin
            x = m_step(x);
            acc[32*k +: 32] = x;
        end
        s_end = x;
        return acc[IN_W-1:0];
    endfunction

    function automatic logic [31:0] m_fold(input logic [OUT_W-1:0] o);
        logic [191:0] wide;
        logic [31:0]  f;
        wide = 192'(o);
        f    = '0;
        for (int k = 0; k < 6; k++) f = f ^ wide[32*k +: 32];
        return f;
    endfunction

    function automatic logic [OUT_W-1:0] gen_out(input int mode);
        logic [191:0] r;
        for (int k = 0; k < 6; k++) r[32*k +: 32] = $urandom();
        case (mode)
            0:       return '0;
            1:       return OUT_W'(1);
            default: return r[OUT_W-1:0];
        endcase
    endfunction

    // monitor: pops one expectation per clock while a run is tracked
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_t'(exp_q.pop_front());
            chk("busy",      bus.busy,      mon_e.busy);
            chk("done",      bus.done,      mon_e.done);
            chk("dut_rst_n", bus.dut_rst_n, mon_e.drst);
            chk("in_flat",   bus.in_flat,   mon_e.in_flat);
            chk("cyc_cnt",   bus.cyc_cnt,   mon_e.cyc);
            chk("signature", bus.signature, mon_e.sig);
        end
    end

    task automatic abort_run();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_dut_rst_n", bus.dut_rst_n, 1'b0);
        chk("abort_in_flat",   bus.in_flat,   '0);
        chk("abort_busy",      bus.busy,      1'b0);
        chk("abort_done",      bus.done,      1'b0);
        chk("abort_cyc_cnt",   bus.cyc_cnt,   32'd0);
        chk("abort_signature", bus.signature, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_abort_state", dbg_state, IDLE);
        chk("post_abort_busy",  bus.busy,  1'b0);
        chk("post_abort_rst",   bus.dut_rst_n, 1'b0);
    endtask

    // driver: issues one start and pushes the expected view of every following clock
    task automatic run_case(input logic [31:0] seed, input logic [31:0] n, input int mode,
                            input int spur_at, input int abort_at,
                            input bit chk_w0, input logic [31:0] w0,
                            input bit chk_sig, input logic [31:0] sig_exp);
        logic [IN_W-1:0] vec_m;
        logic [31:0]     lcg_m, lcg_nx, cyc_m, sig_m;
        exp_t            e;
        int              total;
        @(posedge clk);
        #1;
        bus.start      = 1'b1;
        bus.seed       = seed;
        bus.num_cycles = n;
        bus.out_flat   = gen_out(mode);
        vec_m = m_vector(seed, lcg_m);
        cyc_m = '0;
        sig_m = '0;
        total = R + 4 + int'(n);
        for (int i = 0; i < total; i++) begin
            @(posedge clk);
            if (i >= R + 2 && cyc_m < n) begin
                sig_m = {sig_m[30:0], sig_m[31]} ^ m_fold(bus.out_flat);
                vec_m = m_vector(lcg_m, lcg_nx);
                lcg_m = lcg_nx;
                cyc_m = cyc_m + 32'd1;
            end
            e.busy    = (i <= R) || (cyc_m < n);
            e.done    = !e.busy;
            e.drst    = (i >= R);
            e.in_flat = vec_m;
            e.cyc     = cyc_m;
            e.sig     = sig_m;
            exp_q.push_back(e);
            #1;
            if (i == 0 && chk_w0) chk("first_word", bus.in_flat[31:0], w0);
            bus.start = 1'b0;
            if (spur_at >= 0 && i >= R + 1 && cyc_m == 32'(spur_at) && e.busy) begin
                bus.start      = 1'b1;
                bus.seed       = $urandom();
                bus.num_cycles = $urandom_range(1, 50);
            end
            bus.out_flat = gen_out(mode);
            if (abort_at >= 0 && i >= R + 1 && cyc_m == 32'(abort_at)) begin
                abort_run();
                return;
            end
        end
        if (chk_sig) chk("final_signature", bus.signature, sig_exp);
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.start      = 1'b0;
        bus.seed       = '0;
        bus.num_cycles = '0;
        bus.out_flat   = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_dut_rst_n", bus.dut_rst_n, 1'b0);
        chk("rst_in_flat",   bus.in_flat,   '0);
        chk("rst_busy",      bus.busy,      1'b0);
        chk("rst_done",      bus.done,      1'b0);
        chk("rst_cyc_cnt",   bus.cyc_cnt,   32'd0);
        chk("rst_signature", bus.signature, 32'd0);
        chk("rst_state",     dbg_state,     IDLE);
        rst_n = 1'b1;

        run_case(32'd0, 32'd0, 2, -1, -1, 1'b1, 32'h00003039, 1'b0, 32'd0);
        run_case(32'd1, 32'd4, 2, -1, -1, 1'b1, 32'h41C67EA6, 1'b0, 32'd0);
        run_case($urandom(), 32'd3, 1, -1, -1, 1'b0, 32'd0, 1'b1, 32'h7);
        run_case($urandom(), 32'd100, 0, -1, -1, 1'b0, 32'd0, 1'b1, 32'd0);
        run_case($urandom(), 32'd10, 2, 1, -1, 1'b0, 32'd0, 1'b0, 32'd0);
        run_case($urandom(), 32'd6, 2, 5, -1, 1'b0, 32'd0, 1'b0, 32'd0);
        run_case($urandom(), 32'd1, 2, -1, -1, 1'b0, 32'd0, 1'b0, 32'd0);
        run_case($urandom(), 32'd20, 2, -1, 5, 1'b0, 32'd0, 1'b0, 32'd0);
        run_case($urandom(), 32'd8, 2, -1, -1, 1'b0, 32'd0, 1'b0, 32'd0);
        for (int t = 0; t < 4; t++) begin
            run_case($urandom(), 32'($urandom_range(0, 20)), 2, -1, -1, 1'b0, 32'd0, 1'b0, 32'd0);
        end

        repeat (2) @(posedge clk);
        #1;
        chk("queue_drain", 192'(exp_q.size()), 192'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
